soc_bus_ctrl: RTL and testbench

SOC_BUS_CTRL -- requirements
Module: soc_bus_ctrl

---
 rtl/soc_bus_pkg.sv | 15 +
 rtl/soc_irq_ctrl.sv | 32 +++
 rtl/soc_bus_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_soc_bus_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared types and register offsets for the peripheral bus controller
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word offsets inside the internal register window
    localparam int REG_PEND    = 0;
    localparam int REG_MASK    = 1;
    localparam int REG_ERRADDR = 2;

endpackage

// File: rtl/soc_irq_ctrl.sv
// rtl/soc_irq_ctrl.sv - interrupt pending/mask registers and aggregated interrupt
module soc_irq_ctrl #(
    parameter int NSLV = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSLV-1:0] s_irq,
    input  logic            pend_wr,
    input  logic            mask_wr,
    input  logic [NSLV-1:0] wdata,
    output logic [NSLV-1:0] pend,
    output logic [NSLV-1:0] mask,
    output logic            irq
);

    // Pending bits: write-1-to-clear, a live request always wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~(pend_wr ? wdata : '0)) | s_irq;
            if (mask_wr) begin
                mask <= wdata;
            end
        end
    end

    // Interrupt output comes from registered state only
    assign irq = |(pend & mask);

endmodule

// File: rtl/soc_bus_ctrl.sv
// rtl/soc_bus_ctrl.sv - master-to-peripheral bus controller with decode, timeout and interrupt window
module soc_bus_ctrl
    import soc_bus_pkg::*;
#(
    parameter int          NSLV    = 4,
    parameter int          DW      = 32,
    parameter int          AW      = 32,
    parameter int          SLV_AW  = 6,
    parameter logic [31:0] BASE    = 32'h0000_4000,
    parameter int          TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wd,
    output logic [DW-1:0]      m_rd,
    output logic               m_ack,
    output logic               m_err,
    output logic [NSLV-1:0]    s_cs,
    output logic               s_we,
    output logic [SLV_AW-3:0]  s_addr,
    output logic [DW-1:0]      s_wd,
    input  logic [NSLV*DW-1:0] s_rd,
    input  logic [NSLV-1:0]    s_ready,
    input  logic [NSLV-1:0]    s_irq,
    output logic               irq
);

    localparam int IW = $clog2(NSLV + 1);
    localparam int WW = SLV_AW - 2;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] BASE_A = AW'(BASE);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wd_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rd_q;
    logic            err_q;
    logic [AW-1:0]   erraddr_q;

    logic [IW-1:0]   req_idx;
    logic [WW-1:0]   req_word;
    logic            base_hit, req_int, req_miss;
    logic            sel_ready, timeout;
    logic [DW-1:0]   sel_rd, int_rd;
    logic            reg_acc;
    logic [NSLV-1:0] pend, mask;

    assign req_idx  = m_addr[SLV_AW +: IW];
    assign req_word = m_addr[SLV_AW-1:2];
    assign base_hit = (m_addr[AW-1:SLV_AW+IW] == BASE_A[AW-1:SLV_AW+IW]);
    assign req_int  = base_hit && (req_idx == IW'(NSLV));
    assign req_miss = !(base_hit && (req_idx <= IW'(NSLV)));
    assign timeout  = (cnt_q == CW'(TIMEOUT - 1));
    assign reg_acc  = (state_q == IDLE) && m_req && req_int;

    // Pick the ready flag and read data of the latched slave only
    always_comb begin
        sel_ready = 1'b0;
        sel_rd    = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = s_ready[i];
                sel_rd    = s_rd[i*DW +: DW];
            end
        end
    end

    // Internal register window read mux; unused words read as zero
    always_comb begin
        int_rd = '0;
        case (req_word)
            WW'(REG_PEND):    int_rd = DW'(pend);
            WW'(REG_MASK):    int_rd = DW'(mask);
            WW'(REG_ERRADDR): int_rd = DW'(erraddr_q);
            default:          int_rd = '0;
        endcase
    end

    soc_irq_ctrl #(
        .NSLV (NSLV)
    ) u_irq (
        .clk     (clk),
        .reset_n (reset_n),
        .s_irq   (s_irq),
        .pend_wr (reg_acc && m_we && (req_word == WW'(REG_PEND))),
        .mask_wr (reg_acc && m_we && (req_word == WW'(REG_MASK))),
        .wdata   (m_wd[NSLV-1:0]),
        .pend    (pend),
        .mask    (mask),
        .irq     (irq)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RESP always returns to IDLE so m_req is not seen there
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (m_req) state_d = (req_miss || req_int) ? RESP : WAIT;
            WAIT: if (sel_ready || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access latches, wait counter and response capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_req) begin
                        addr_q <= m_addr;
                        cnt_q  <= '0;
                        if (req_miss) begin
                            err_q     <= 1'b1;
                            rd_q      <= '0;
                            erraddr_q <= m_addr;
                        end else if (req_int) begin
                            err_q <= 1'b0;
                            rd_q  <= m_we ? '0 : int_rd;
                        end else begin
                            idx_q <= req_idx;
                            we_q  <= m_we;
                            wd_q  <= m_wd;
                            err_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (sel_ready) begin
                        err_q <= 1'b0;
                        rd_q  <= we_q ? '0 : sel_rd;
                    end else if (timeout) begin
                        err_q     <= 1'b1;
                        rd_q      <= '0;
                        erraddr_q <= addr_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decoded from the current state and latched access
    always_comb begin
        m_ack  = (state_q == RESP);
        m_err  = (state_q == RESP) && err_q;
        m_rd   = rd_q;
        s_we   = (state_q == WAIT) && we_q;
        s_addr = addr_q[SLV_AW-1:2];
        s_wd   = wd_q;
        s_cs   = '0;
        for (int i = 0; i < NSLV; i++) begin
            s_cs[i] = (state_q == WAIT) && (idx_q == IW'(i));
        end
    end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// tb/tb_soc_bus_ctrl.sv - self-checking bench for soc_bus_ctrl
module tb_soc_bus_ctrl;

    localparam int NSLV    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic              clk, reset_n;
    logic              m_req, m_we;
    logic [31:0]       m_addr, m_wd, m_rd;
    logic              m_ack, m_err;
    logic [NSLV-1:0]   s_cs;
    logic              s_we;
    logic [3:0]        s_addr;
    logic [31:0]       s_wd;
    logic [NSLV*DW-1:0] s_rd;
    logic [NSLV-1:0]   s_ready, s_irq;
    logic              irq;

    soc_bus_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wd    (m_wd),
        .m_rd    (m_rd),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_cs    (s_cs),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wd    (s_wd),
        .s_rd    (s_rd),
        .s_ready (s_ready),
        .s_irq   (s_irq),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ack_count = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          delay;
        logic [3:0]  junk;
        logic [31:0] erd;
        logic        eerr;
        logic [3:0]  ecs;
        int          elat;
        string       name;
    } vec_t;
    vec_t vt[15];

    // Slave responder state
    int          wcnt = 0;
    int          delay_cfg = NEVER;
    logic [3:0]  junk = '0;
    logic [3:0]  seen_cs, seen_addr;
    logic        seen_we;
    logic [31:0] seen_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: selected slave answers delay_cfg cycles after its select appears
    always @(negedge clk) begin
        if (s_cs != '0) begin
            wcnt++;
            seen_cs   = s_cs;
            seen_we   = s_we;
            seen_addr = s_addr;
            seen_wd   = s_wd;
            s_ready   = ((wcnt == delay_cfg + 1) ? s_cs : 4'b0) | (junk & ~s_cs);
        end else begin
            wcnt    = 0;
            s_ready = junk;
        end
    end

    // Scoreboard: every acknowledge consumes one expected response
    always @(negedge clk) begin
        if (reset_n && m_ack) begin
            exp_t e;
            ack_count++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with rd %h err %0d, required no ack", m_rd, m_err);
            end else begin
                e = sbq.pop_front();
                chk("sb_rd", m_rd, e.rd);
                chk("sb_err", {31'b0, m_err}, {31'b0, e.err});
            end
        end
    end

    task automatic do_access(input vec_t v);
        int lat;
        bit got;
        exp_t e;
        e.rd  = v.erd;
        e.err = v.eerr;
        @(negedge clk);
        seen_cs   = '0;
        delay_cfg = v.delay;
        junk      = v.junk;
        sbq.push_back(e);
        m_req  = 1'b1;
        m_we   = v.we;
        m_addr = v.addr;
        m_wd   = v.wd;
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (m_ack) got = 1;
        end
        m_req = 1'b0;
        junk  = '0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_no_ack: got no ack in 200 cycles, required ack", v.name);
            sbq.delete();
        end else begin
            chk({v.name, "_lat"}, lat, v.elat);
            chk({v.name, "_cs"}, {28'b0, seen_cs}, {28'b0, v.ecs});
            chk({v.name, "_cs_off"}, {28'b0, s_cs}, 32'b0);
            if (v.ecs != '0) begin
                chk({v.name, "_saddr"}, {28'b0, seen_addr}, {28'b0, v.addr[5:2]});
                chk({v.name, "_swe"}, {31'b0, seen_we}, {31'b0, v.we});
                if (v.we) chk({v.name, "_swd"}, seen_wd, v.wd);
            end
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eerr, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.delay = 0; v.junk = '0;
        v.erd = erd; v.eerr = eerr; v.ecs = '0; v.elat = 1; v.name = name;
        return v;
    endfunction

    initial begin : main
        logic [3:0] pat;
        int acks_before;
        vec_t v;

        vt[0]  = '{1'b0, 32'h4080, 32'h0, 3, 4'b0, 32'hCAFE_0002, 1'b0, 4'b0100, 5, "rd_s2"};
        vt[1]  = '{1'b1, 32'h4004, 32'h1234_5678, 0, 4'b0, 32'h0, 1'b0, 4'b0001, 2, "wr_s0"};
        vt[2]  = '{1'b0, 32'h40FC, 32'h0, 1, 4'b0, 32'hCAFE_0003, 1'b0, 4'b1000, 3, "rd_s3"};
        vt[3]  = '{1'b0, 32'h4044, 32'h0, 2, 4'b1101, 32'hCAFE_0001, 1'b0, 4'b0010, 4, "rd_s1_junk"};
        vt[4]  = mk(1'b1, 32'h8000, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_miss");
        vt[5]  = mk(1'b0, 32'h4108, 32'h0, 32'h8000, 1'b0, "rd_erraddr1");
        vt[6]  = mk(1'b1, 32'h4104, 32'h2, 32'h0, 1'b0, "wr_mask");
        vt[7]  = mk(1'b0, 32'h4104, 32'h0, 32'h2, 1'b0, "rd_mask");
        vt[8]  = mk(1'b1, 32'h4108, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr_erraddr_ro");
        vt[9]  = mk(1'b0, 32'h4108, 32'h0, 32'h8000, 1'b0, "rd_erraddr2");
        vt[10] = mk(1'b0, 32'h4140, 32'h0, 32'h0, 1'b1, "rd_miss_idx5");
        vt[11] = '{1'b0, 32'h4040, 32'h0, NEVER, 4'b0, 32'h0, 1'b1, 4'b0010, TIMEOUT + 1, "rd_timeout"};
        vt[12] = mk(1'b0, 32'h410C, 32'h0, 32'h0, 1'b0, "rd_word3");
        vt[13] = mk(1'b0, 32'h4100, 32'h0, 32'h0, 1'b0, "rd_pend0");
        vt[14] = mk(1'b0, 32'h4108, 32'h0, 32'h4040, 1'b0, "rd_erraddr3");

        for (int i = 0; i < NSLV; i++) s_rd[i*DW +: DW] = 32'hCAFE_0000 | 32'(i);
        reset_n = 1'b0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
        s_irq = '0; s_ready = '0;

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, m_ack}, 32'b0);
        chk("rst_err", {31'b0, m_err}, 32'b0);
        chk("rst_cs", {28'b0, s_cs}, 32'b0);
        chk("rst_we", {31'b0, s_we}, 32'b0);
        chk("rst_rd", m_rd, 32'b0);
        chk("rst_irq", {31'b0, irq}, 32'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) do_access(vt[i]);

        repeat (3) @(negedge clk);
        chk("rd_hold", m_rd, 32'h4040);

        // Interrupt: MASK is 2 from the table
        @(negedge clk);
        s_irq = 4'b0010;
        @(negedge clk);
        s_irq = 4'b0000;
        @(negedge clk);
        chk("irq_set", {31'b0, irq}, 32'b1);
        s_irq = 4'b0010;
        do_access(mk(1'b1, 32'h4100, 32'h2, 32'h0, 1'b0, "wr_pend_busy"));
        do_access(mk(1'b0, 32'h4100, 32'h0, 32'h2, 1'b0, "rd_pend_kept"));
        chk("irq_kept", {31'b0, irq}, 32'b1);
        s_irq = 4'b0000;
        do_access(mk(1'b1, 32'h4100, 32'h2, 32'h0, 1'b0, "wr_pend_clr"));
        do_access(mk(1'b0, 32'h4100, 32'h0, 32'h0, 1'b0, "rd_pend_clr"));
        chk("irq_clr", {31'b0, irq}, 32'b0);

        // Back-to-back: m_req held through two MASK reads
        v = mk(1'b0, 32'h4104, 32'h0, 32'h2, 1'b0, "b2b");
        @(negedge clk);
        sbq.push_back('{32'h2, 1'b0});
        sbq.push_back('{32'h2, 1'b0});
        m_req = 1'b1; m_we = v.we; m_addr = v.addr;
        pat = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            pat[c-1] = m_ack;
            if (c == 3) m_req = 1'b0;
        end
        chk("b2b_pattern", {28'b0, pat}, 32'h5);

        // Reset in the middle of a slave wait
        @(negedge clk);
        s_irq = 4'b1000;
        @(negedge clk);
        s_irq = 4'b0000;
        delay_cfg = NEVER;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4080;
        repeat (3) @(negedge clk);
        chk("mid_wait_cs", {28'b0, s_cs}, 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cs", {28'b0, s_cs}, 32'b0);
        chk("async_irq", {31'b0, irq}, 32'b0);
        m_req = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        acks_before = ack_count;
        repeat (6) @(negedge clk);
        chk("no_ack_after_rst", ack_count, acks_before);
        do_access(mk(1'b0, 32'h4104, 32'h0, 32'h0, 1'b0, "rst_mask"));
        do_access(mk(1'b0, 32'h4100, 32'h0, 32'h0, 1'b0, "rst_pend"));
        do_access(mk(1'b0, 32'h4108, 32'h0, 32'h0, 1'b0, "rst_erraddr"));

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
